instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes R/I/J instruction field bundles into 32-bit words and buffers them
// in a small FIFO with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] jump_address,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        full,
  output logic        empty,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry layout is {err, word}; illegal bundles always carry a zero word.
  function automatic logic [32:0] encode_entry(
    input logic [1:0]  f,
    input logic [5:0]  op,
    input logic [4:0]  s,
    input logic [4:0]  t,
    input logic [4:0]  d,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] imm,
    input logic [25:0] ja
  );
    logic [32:0] e;
    e = {1'b1, 32'h0000_0000};
    case (f)
      2'b00: begin
        if (op == 6'd0) e = {1'b0, op, s, t, d, sh, fn};
        else            e = {1'b1, 32'h0000_0000};
      end
      2'b01: begin
        if ((op != 6'd0) && (op != 6'd2) && (op != 6'd3)) e = {1'b0, op, s, t, imm};
        else                                              e = {1'b1, 32'h0000_0000};
      end
      2'b10: begin
        if ((op == 6'd2) || (op == 6'd3)) e = {1'b0, op, ja};
        else                              e = {1'b1, 32'h0000_0000};
      end
      default: e = {1'b1, 32'h0000_0000};
    endcase
    return e;
  endfunction

  logic [32:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   enc_count_r;
  logic [7:0]    err_count_r;
  logic [32:0]   entry_s;
  logic [32:0]   head_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == FULL_CNT);
  assign in_ready  = !full_s && !rst;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready && !rst;

  // Encode the incoming bundle and select the head entry for presentation.
  always_comb begin
    entry_s = encode_entry(fmt, opcode, rs, rt, rd, shamt, funct, immediate, jump_address);
    if (empty_s) head_s = {1'b0, 32'h0000_0000};
    else         head_s = mem_r[rd_ptr_r];
  end

  assign out_instr = head_s[31:0];
  assign out_err   = head_s[32];
  assign full      = full_s;
  assign empty     = empty_s;
  assign enc_count = enc_count_r;
  assign err_count = err_count_r;

  // FIFO storage; no reset needed since occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= entry_s;
  end

  // Pointers, occupancy and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      enc_count_r <= 16'd0;
      err_count_r <= 8'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_s) enc_count_r <= enc_count_r + 16'd1;
      // Error counter sticks at its maximum instead of wrapping.
      if (push_s && entry_s[32] && (err_count_r != 8'hFF)) err_count_r <= err_count_r + 8'd1;
    end
  end

endmodule
